seg_disp: RTL
=============

SEG_DISP -- requirements
Module: seg_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (1 kHz slot rate at 50 MHz clk); legal range 4..2^24-1.
REQ-002 SHALL have parameter GUARD, default 16, clocks at slot start with all digits off (ghost suppression); legal range 0..SCAN_DIV-2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  chip select from the CPU bus.
REQ-006 SHALL have port we  input  1  write strobe; 1 = write, 0 = read.
REQ-007 SHALL have port addr  input  3  register address: 0-3 digit registers, 4 control register, 5-7 unused.
REQ-008 SHALL have port wrdat  input  8  write data.
REQ-009 SHALL have port rddat  output  8  read data; 8'h00 when not selected.
REQ-010 SHALL have port SEG  output  8  segment lines {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port DIG  output  4  digit enables, active-low, one-hot-low when lit.
REQ-012 SHALL have port frame  output  1  one-clock pulse at each scan wrap from digit 3 to digit 0.

Function
REQ-013 SHALL write wrdat into register addr on a clk edge where cs=1 and we=1; new value visible on rddat and the display from the next cycle.
REQ-014 SHALL ignore writes to addr 5-7 with no side effects.
REQ-015 SHALL drive rddat combinationally: register[addr] when cs=1 and we=0, else 8'h00; addr 5-7 read 8'h00.
REQ-016 SHALL implement control register bit0 EN (1 = display on); bits 7:1 read back as written and have no function.
REQ-017 SHALL run a slot counter 0..SCAN_DIV-1 continuously regardless of EN; at count SCAN_DIV-1 it returns to 0 and digit index advances 0->1->2->3->0.
REQ-018 SHALL assert frame for exactly one clock on the same edge the index wraps 3->0.
REQ-019 SHALL drive DIG=4'hF and SEG=8'hFF while slot counter < GUARD or EN=0.
REQ-020 SHALL otherwise drive DIG low on bit index only and SEG from digit register[index].
REQ-021 SHALL register SEG and DIG outputs (one-clock latency from counter/index/register state to pins).
REQ-022 SHALL, on a write to the currently displayed digit mid-slot, show the new pattern from the second edge after the write; no slot restart.
REQ-023 SHALL give a simultaneous write and slot-wrap no mutual effect: write lands, index advances normally.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, clear digit registers to 8'h00, set control to 8'h01, clear slot counter and index to 0, and drive frame=0, DIG=4'hF, SEG=8'hFF.
REQ-025 SHALL take reset priority over any simultaneous bus write; reset mid-slot restarts scanning at digit 0, counter 0.

Configuration
REQ-026 SHALL support macro SEG_DISP_HEX_DECODE_EN: when defined, bits 3:0 of a digit register decode hex 0-F to segments a-g (standard patterns, e.g. 0 -> a-f on, 1 -> b,c on) and bit7 drives dp; bits 6:4 ignored.
REQ-027 SHALL, without SEG_DISP_HEX_DECODE_EN, treat digit registers as raw active-high segment patterns, SEG = ~register[index].

Verification (bench: SCAN_DIV=8, GUARD=2)
REQ-028 SHALL check reset: after rst, DIG=4'hF, SEG=8'hFF, reading addr 4 returns 8'h01, addr 0-3 return 8'h00.
REQ-029 SHALL check write/read: write 8'hA5 to addr 2 -> read addr 2 = 8'hA5; write addr 6 then read addr 6 = 8'h00; cs=0 -> rddat=8'h00.
REQ-030 SHALL check scan: DIG sequence 4'hE,4'hD,4'hB,4'h7 each lit 6 clocks after 2 dark clocks; frame pulses once every 32 clocks.
REQ-031 SHALL check decode (macro on): addr 0 = 8'h81 -> SEG=8'h79 during digit 0; macro off, addr 0 = 8'h3F -> SEG=8'hC0.
REQ-032 SHALL check EN: write 8'h00 to addr 4 -> DIG=4'hF continuously while frame still pulses every 32 clocks; rewrite 8'h01 restores scan.
REQ-033 SHALL check reset mid-slot at digit 2 with pending write: digit registers cleared, scanning resumes at digit 0 after GUARD clocks.

Source files
------------

// File: rtl/seg_disp.sv
// rtl/seg_disp.sv - bus-programmed 4-digit multiplexed 7-segment scan driver (optional hex decode: SEG_DISP_HEX_DECODE_EN)
module seg_disp #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wrdat,
    output logic [7:0] rddat,
    output logic [7:0] SEG,
    output logic [3:0] DIG,
    output logic       frame
);

    localparam logic [23:0] SLOT_LAST = 24'(SCAN_DIV - 1);
    localparam logic [23:0] GUARD_END = 24'(GUARD);

    logic [7:0]  dig_reg [4];
    logic [7:0]  ctrl;
    logic [23:0] cnt;
    logic [1:0]  idx;
    logic [7:0]  cur_pat;
    logic [7:0]  seg_next;
    logic        dark;

    // Bus writes to digit and control registers; addresses 5-7 fall through untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) dig_reg[i] <= 8'h00;
            ctrl <= 8'h01;
        end else if (cs && we) begin
            if (addr < 3'd4)
                dig_reg[addr[1:0]] <= wrdat;
            else if (addr == 3'd4)
                ctrl <= wrdat;
        end
    end

    // Combinational read mux, zero when not selected or unmapped
    always_comb begin
        rddat = 8'h00;
        if (cs && !we) begin
            if (addr < 3'd4)
                rddat = dig_reg[addr[1:0]];
            else if (addr == 3'd4)
                rddat = ctrl;
        end
    end

    // Free-running slot counter and digit index; frame marks the 3->0 wrap edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 24'd0;
            idx   <= 2'd0;
            frame <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (cnt == SLOT_LAST) begin
                cnt   <= 24'd0;
                idx   <= idx + 2'd1;
                frame <= (idx == 2'd3);
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end

    // Segment pattern for the digit currently in its slot (active-low result)
    always_comb begin
        cur_pat  = dig_reg[idx];
        seg_next = 8'hFF;
`ifdef SEG_DISP_HEX_DECODE_EN
        case (cur_pat[3:0])
            4'h0: seg_next = ~{cur_pat[7], 7'h3F};
            4'h1: seg_next = ~{cur_pat[7], 7'h06};
            4'h2: seg_next = ~{cur_pat[7], 7'h5B};
            4'h3: seg_next = ~{cur_pat[7], 7'h4F};
            4'h4: seg_next = ~{cur_pat[7], 7'h66};
            4'h5: seg_next = ~{cur_pat[7], 7'h6D};
            4'h6: seg_next = ~{cur_pat[7], 7'h7D};
            4'h7: seg_next = ~{cur_pat[7], 7'h07};
            4'h8: seg_next = ~{cur_pat[7], 7'h7F};
            4'h9: seg_next = ~{cur_pat[7], 7'h6F};
            4'hA: seg_next = ~{cur_pat[7], 7'h77};
            4'hB: seg_next = ~{cur_pat[7], 7'h7C};
            4'hC: seg_next = ~{cur_pat[7], 7'h39};
            4'hD: seg_next = ~{cur_pat[7], 7'h5E};
            4'hE: seg_next = ~{cur_pat[7], 7'h79};
            default: seg_next = ~{cur_pat[7], 7'h71};
        endcase
`else
        seg_next = ~cur_pat;
`endif
        dark = (cnt < GUARD_END) || !ctrl[0];
    end

    // Registered pin drivers; blank during the guard window or when disabled
    always_ff @(posedge clk) begin
        if (rst || dark) begin
            DIG <= 4'hF;
            SEG <= 8'hFF;
        end else begin
            DIG <= ~(4'b0001 << idx);
            SEG <= seg_next;
        end
    end

endmodule
